// File: rtl/vga_pkg.sv
// Shared VGA raster constants and the sync bundle carried through the output delay chain.
// The frame buffer imports the same package for its frame dimensions.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_SCALE_SHIFT = 2;
  localparam int DEF_PIPE_LAT    = 1;

  // Frame-buffer dimensions after downscaling; both must stay <= 256 for 8-bit coordinates.
  localparam int FRAME_W = DEF_H_ACTIVE >> DEF_SCALE_SHIFT;
  localparam int FRAME_H = DEF_V_ACTIVE >> DEF_SCALE_SHIFT;

  localparam int CNT_W   = 10;
  localparam int COORD_W = 8;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } vga_sync_t;

  // Blanked, syncs deasserted (active-low).
  localparam vga_sync_t SYNC_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

  // True when lo <= cnt < hi.
  function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int lo, input int hi);
    return (int'(cnt) >= lo) && (int'(cnt) < hi);
  endfunction

endpackage

// File: rtl/vga_delay.sv
// Fixed-depth shift register for the sync bundle; clear loads every stage with the idle value.
// DEPTH must be at least 1.
module vga_delay
  import vga_pkg::*;
#(
  parameter int        DEPTH    = 1,
  parameter vga_sync_t IDLE_VAL = SYNC_IDLE
) (
  input  logic      clk_i,
  input  logic      clr_i,
  input  vga_sync_t d_i,
  output vga_sync_t q_o
);

  vga_sync_t stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= IDLE_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// Free-running raster counters, sync/active decode and downscaled pixel coordinates.
// Sync/active are delayed PIPE_LAT cycles to align with frame-buffer read data.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int PIPE_LAT    = DEF_PIPE_LAT
) (
  input  logic               i_vga_clk,
  input  logic               i_rst,
  input  logic               en_VGA,
  output logic [COORD_W-1:0] o_pxlX,
  output logic [COORD_W-1:0] o_pxlY,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_active,
  output logic               o_frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    end
    // Disabled raster parks at (0,0) so it restarts a fresh frame on enable.
    if (!en_VGA) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end
  end

  always_ff @(posedge i_vga_clk) begin
    if (i_rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  logic      act_raw;
  vga_sync_t sync_raw;
  vga_sync_t sync_dly;

  assign act_raw = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);

  assign sync_raw.active = act_raw;
  assign sync_raw.hsync  = !in_window(h_cnt_q, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
  assign sync_raw.vsync  = !in_window(v_cnt_q, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);

  vga_delay #(
    .DEPTH    (PIPE_LAT),
    .IDLE_VAL (SYNC_IDLE)
  ) u_delay (
    .clk_i (i_vga_clk),
    .clr_i (i_rst || !en_VGA),
    .d_i   (sync_raw),
    .q_o   (sync_dly)
  );

  assign o_active = sync_dly.active;
  assign o_hsync  = sync_dly.hsync;
  assign o_vsync  = sync_dly.vsync;

  assign o_pxlX = act_raw ? COORD_W'(h_cnt_q >> SCALE_SHIFT) : '0;
  assign o_pxlY = act_raw ? COORD_W'(v_cnt_q >> SCALE_SHIFT) : '0;

  // Reset masks the pulse even though the counters already sit at (0,0).
  assign o_frameStart = en_VGA && !i_rst && (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a full-size instance (PIPE_LAT=1) and a shrunken-raster instance (PIPE_LAT=3),
// both checked every cycle against a reference raster model plus directed corner sequences.
module tb_vga_timing;

  localparam int A_HA = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
  localparam int A_VA = 480, A_VFP = 10, A_VS = 2,  A_VBP = 33;
  localparam int A_SH = 2,   A_LAT = 1;

  localparam int B_HA = 32, B_HFP = 4, B_HS = 8, B_HBP = 6;
  localparam int B_VA = 16, B_VFP = 2, B_VS = 2, B_VBP = 3;
  localparam int B_SH = 2,  B_LAT = 3;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, sh, lat;
  } tcfg_t;

  typedef struct {
    int         h;
    logic [7:0] x;
    logic       hs;
    logic       act;
  } line_vec_t;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_x, a_y, b_x, b_y;
  logic       a_hs, a_vs, a_act, a_fs;
  logic       b_hs, b_vs, b_act, b_fs;

  vga_timing #(
    .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .SCALE_SHIFT(A_SH), .PIPE_LAT(A_LAT)
  ) dut_a (
    .i_vga_clk(clk), .i_rst(rst), .en_VGA(en),
    .o_pxlX(a_x), .o_pxlY(a_y), .o_hsync(a_hs), .o_vsync(a_vs),
    .o_active(a_act), .o_frameStart(a_fs)
  );

  vga_timing #(
    .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .SCALE_SHIFT(B_SH), .PIPE_LAT(B_LAT)
  ) dut_b (
    .i_vga_clk(clk), .i_rst(rst), .en_VGA(en),
    .o_pxlX(b_x), .o_pxlY(b_y), .o_hsync(b_hs), .o_vsync(b_vs),
    .o_active(b_act), .o_frameStart(b_fs)
  );

  // Scoreboard state: model counters and expected delayed {active,hsync,vsync}
  tcfg_t      cfg [2];
  int         m_h [2];
  int         m_v [2];
  logic [2:0] exp_q0[$];
  logic [2:0] exp_q1[$];
  int         fs_a_q[$];
  int         fs_b_q[$];
  int         tests = 0;
  int         fails = 0;
  line_vec_t  tbl [14];
  int         hs_run, act_run, vs_run;

  function automatic logic [2:0] decode(input tcfg_t c, input int h, input int v);
    logic a, hs, vs;
    a  = (h < c.ha) && (v < c.va);
    hs = !((h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsw));
    vs = !((v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsw));
    return {a, hs, vs};
  endfunction

  function automatic logic [19:0] expect_vec(input int i, input logic [2:0] dly);
    logic [2:0] raw;
    logic [7:0] x, y;
    logic       fs;
    raw = decode(cfg[i], m_h[i], m_v[i]);
    x   = raw[2] ? 8'((m_h[i] >> cfg[i].sh) & 255) : 8'd0;
    y   = raw[2] ? 8'((m_v[i] >> cfg[i].sh) & 255) : 8'd0;
    fs  = en && !rst && (m_h[i] == 0) && (m_v[i] == 0);
    return {x, y, dly, fs};
  endfunction

  task automatic model_clock(input int i);
    logic [2:0] d;
    int ht, vt;
    bit clr;
    ht  = cfg[i].ha + cfg[i].hfp + cfg[i].hsw + cfg[i].hbp;
    vt  = cfg[i].va + cfg[i].vfp + cfg[i].vsw + cfg[i].vbp;
    d   = decode(cfg[i], m_h[i], m_v[i]);
    clr = rst || !en;
    if (clr) begin
      m_h[i] = 0;
      m_v[i] = 0;
    end else if (m_h[i] == ht - 1) begin
      m_h[i] = 0;
      m_v[i] = (m_v[i] == vt - 1) ? 0 : m_v[i] + 1;
    end else begin
      m_h[i] = m_h[i] + 1;
    end
    if (i == 0) begin
      if (clr) begin
        exp_q0.delete();
        repeat (cfg[0].lat) exp_q0.push_back(3'b011);
      end else begin
        void'(exp_q0.pop_front());
        exp_q0.push_back(d);
      end
    end else begin
      if (clr) begin
        exp_q1.delete();
        repeat (cfg[1].lat) exp_q1.push_back(3'b011);
      end else begin
        void'(exp_q1.pop_front());
        exp_q1.push_back(d);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // Driver tasks: step advances one clock and the model; sample compares outputs mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
    model_clock(0);
    model_clock(1);
  endtask

  task automatic sample();
    #1;
    check("sb_a", {12'd0, a_x, a_y, a_act, a_hs, a_vs, a_fs}, {12'd0, expect_vec(0, exp_q0[0])});
    check("sb_b", {12'd0, b_x, b_y, b_act, b_hs, b_vs, b_fs}, {12'd0, expect_vec(1, exp_q1[0])});
  endtask

  task automatic cycle();
    sample();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    cfg[0] = '{A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, A_SH, A_LAT};
    cfg[1] = '{B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, B_SH, B_LAT};
    // Line-0 sweep of the full-size instance: {hCnt, pxlX, hsync out, active out}
    tbl = '{
      '{1,   8'd0,   1'b1, 1'b1}, '{3,   8'd0,   1'b1, 1'b1},
      '{4,   8'd1,   1'b1, 1'b1}, '{7,   8'd1,   1'b1, 1'b1},
      '{8,   8'd2,   1'b1, 1'b1}, '{636, 8'd159, 1'b1, 1'b1},
      '{639, 8'd159, 1'b1, 1'b1}, '{640, 8'd0,   1'b1, 1'b1},
      '{641, 8'd0,   1'b1, 1'b0}, '{656, 8'd0,   1'b1, 1'b0},
      '{657, 8'd0,   1'b0, 1'b0}, '{752, 8'd0,   1'b0, 1'b0},
      '{753, 8'd0,   1'b1, 1'b0}, '{799, 8'd0,   1'b1, 1'b0}
    };
    for (int i = 0; i < 2; i++) begin
      m_h[i] = 0;
      m_v[i] = 0;
    end
    repeat (A_LAT) exp_q0.push_back(3'b011);
    repeat (B_LAT) exp_q1.push_back(3'b011);

    // Reset with enable already high: reset wins, frameStart masked
    rst = 1'b1;
    en  = 1'b1;
    step();
    repeat (3) cycle();
    sample();
    check("rst_pxlX",  32'(a_x),  32'd0);
    check("rst_pxlY",  32'(a_y),  32'd0);
    check("rst_hsync", 32'(a_hs), 32'd1);
    check("rst_vsync", 32'(a_vs), 32'd1);
    check("rst_act",   32'(a_act), 32'd0);
    check("rst_fs",    32'(a_fs), 32'd0);
    check("rst_fs_b",  32'(b_fs), 32'd0);

    // Free run: 3+ lines of A, 2+ frames of B
    rst = 1'b0;
    fs_a_q.push_back(0);
    fs_b_q.push_back(0);
    fs_b_q.push_back(1150);
    fs_b_q.push_back(2300);
    hs_run  = 0;
    act_run = 0;
    vs_run  = 0;
    for (int c = 0; c < 2600; c++) begin
      sample();
      if (a_fs) begin
        if (fs_a_q.size() > 0) check("fs_a_pos", 32'(c), 32'(fs_a_q.pop_front()));
        else check("fs_a_extra", 32'(c), 32'hFFFF_FFFF);
      end
      if (b_fs) begin
        if (fs_b_q.size() > 0) check("fs_b_pos", 32'(c), 32'(fs_b_q.pop_front()));
        else check("fs_b_extra", 32'(c), 32'hFFFF_FFFF);
      end
      if (m_v[0] == 0) begin
        foreach (tbl[k]) begin
          if (tbl[k].h == m_h[0]) begin
            check("line0_pxlX",  32'(a_x),   32'(tbl[k].x));
            check("line0_hsync", 32'(a_hs),  32'(tbl[k].hs));
            check("line0_act",   32'(a_act), 32'(tbl[k].act));
          end
        end
      end
      if (!a_hs) begin
        if (hs_run == 0) check("hs_start_h", 32'(m_h[0]), 32'(A_HA + A_HFP + A_LAT));
        hs_run++;
      end else if (hs_run > 0) begin
        check("hs_len", 32'(hs_run), 32'(A_HS));
        hs_run = 0;
      end
      if (a_act) begin
        act_run++;
      end else if (act_run > 0) begin
        check("act_len", 32'(act_run), 32'(A_HA));
        act_run = 0;
      end
      if (!b_vs) begin
        if (vs_run == 0) begin
          check("vs_start_v", 32'(m_v[1]), 32'(B_VA + B_VFP));
          check("vs_start_h", 32'(m_h[1]), 32'(B_LAT));
        end
        vs_run++;
      end else if (vs_run > 0) begin
        check("vs_len", 32'(vs_run), 32'(B_VS * (B_HA + B_HFP + B_HS + B_HBP)));
        vs_run = 0;
      end
      if (m_v[1] == B_VA - 1 && m_h[1] == 0) check("last_line_pxlY", 32'(b_y), 32'((B_VA - 1) >> B_SH));
      step();
    end
    check("fs_a_left", 32'(fs_a_q.size()), 32'd0);
    check("fs_b_left", 32'(fs_b_q.size()), 32'd0);

    // Drop enable at hCnt 700: counters park, delayed outputs go idle next cycle
    for (int n = 0; n < 1000 && m_h[0] != 700; n++) cycle();
    en = 1'b0;
    sample();
    step();
    sample();
    check("dis_pxlX",  32'(a_x),   32'd0);
    check("dis_pxlY",  32'(a_y),   32'd0);
    check("dis_act",   32'(a_act), 32'd0);
    check("dis_hsync", 32'(a_hs),  32'd1);
    check("dis_vsync", 32'(a_vs),  32'd1);
    check("dis_fs",    32'(a_fs),  32'd0);
    repeat (4) cycle();

    // Re-enable: frameStart immediately, delayed outputs idle for PIPE_LAT cycles
    en = 1'b1;
    sample();
    check("reen_fs_a",   32'(a_fs),  32'd1);
    check("reen_fs_b",   32'(b_fs),  32'd1);
    check("reen_act_a0", 32'(a_act), 32'd0);
    check("reen_act_b0", 32'(b_act), 32'd0);
    step();
    sample();
    check("reen_act_a1", 32'(a_act), 32'd1);
    check("reen_act_b1", 32'(b_act), 32'd0);
    check("reen_fs_a1",  32'(a_fs),  32'd0);
    step();
    sample();
    check("reen_act_b2", 32'(b_act), 32'd0);
    step();
    sample();
    check("reen_act_b3", 32'(b_act), 32'd1);

    // Reset mid-hsync with enable high: sync released next cycle, reset values restored
    for (int n = 0; n < 1000 && m_h[0] != 700; n++) cycle();
    sample();
    check("midhs_low", 32'(a_hs), 32'd0);
    rst = 1'b1;
    sample();
    step();
    sample();
    check("midhs_rst_hsync", 32'(a_hs),  32'd1);
    check("midhs_rst_act",   32'(a_act), 32'd0);
    check("midhs_rst_pxlX",  32'(a_x),   32'd0);
    check("midhs_rst_pxlY",  32'(a_y),   32'd0);
    check("midhs_rst_vsync", 32'(a_vs),  32'd1);
    check("midhs_rst_fs",    32'(a_fs),  32'd0);
    rst = 1'b0;
    repeat (300) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
